irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter: NUM_IRQ, default 8, number of interrupt channels; legal range 2..32.
REQ-002 Parameter: SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: arst  input  1  asynchronous, active-low reset.
REQ-005 Port: irq_pins  input  NUM_IRQ  raw asynchronous request pins.
REQ-006 Port: irq_edge_sel  input  NUM_IRQ  per-channel mode: 1 = rising-edge, 0 = level-high.
REQ-007 Port: irq_mask  input  NUM_IRQ  per-channel enable, 1 = enabled.
REQ-008 Port: irq_en  input  1  global interrupt enable.
REQ-009 Port: rr_mode  input  1  arbitration mode: 0 = fixed priority, lowest index highest; 1 = round-robin.
REQ-010 Port: int_ack  input  1  one-cycle acknowledge from the microcode sequencer.
REQ-011 Port: eoi  input  1  one-cycle end-of-interrupt.
REQ-012 Port: clear_all  input  1  one-cycle clear of all pending and in-service state.
REQ-013 Port: int_pending  output  1  registered request to the sequencer.
REQ-014 Port: irq_vector  output  8  {zero-extension, channel id, 1'b0}.
REQ-015 Port: irq_status  output  NUM_IRQ  pending register.
REQ-016 Port: in_service  output  NUM_IRQ  in-service register.

Function
REQ-017 Synchronization: each irq_pins bit passes through SYNC_STAGES flops before any use; an edge-history flop follows the last stage.
REQ-018 Pending set, edge channel: set on a synchronized 0->1 transition.
REQ-019 Pending set, level channel: set every cycle the synchronized input is 1.
REQ-020 Pending set is independent of irq_mask; the mask gates arbitration only.
REQ-021 Eligible channel: pending & mask.
- Fixed mode: index strictly lower than the lowest set in_service bit, or in_service == 0 (nesting allowed).
- rr mode: in_service == 0 (no nesting).
REQ-022 Winner, fixed mode: lowest eligible index.
REQ-023 Winner, rr mode: first eligible index searching upward from rr_ptr, with wrap-around modulo NUM_IRQ.
REQ-024 int_pending is registered: irq_en & (any eligible), one cycle after the pending update.
REQ-025 int_ack while int_pending = 1, in one cycle:
- irq_vector <= {winner, 1'b0};
- in_service[winner] <= 1;
- pending[winner] <= 0;
- rr mode only: rr_ptr <= (winner+1) mod NUM_IRQ.
REQ-026 int_ack while int_pending = 0: ignored; all state unchanged.
REQ-027 irq_vector holds its value between acknowledges.
REQ-028 Same-cycle new edge and ack clear on one channel: pending stays 1 (set wins).
REQ-029 Level channel still high after ack: pending re-sets on the next cycle.
REQ-030 eoi clears one in_service bit:
- fixed mode: the lowest-index set bit;
- rr mode: the single set bit.
eoi with in_service == 0 has no effect.
REQ-031 eoi and int_ack in the same cycle: both are evaluated on pre-cycle state. eoi clears its bit; ack sets the winner's bit. If both target the same bit, the bit ends at 1.
REQ-032 clear_all: pending <= 0, in_service <= 0, rr_ptr <= 0, int_pending <= 0. clear_all overrides set, ack and eoi in the same cycle. Synchronizer contents are kept, so no spurious edge follows.
REQ-033 Latency: a pin rising edge sampled at edge k sets pending at edge k+SYNC_STAGES+1 and int_pending at edge k+SYNC_STAGES+2.
REQ-034 Masking a pending channel deasserts int_pending on the next cycle, provided no other channel is eligible; its pending bit is retained.

Reset
REQ-035 arst = 0 asynchronously clears all flops: synchronizers, edge history, pending, in_service, rr_ptr, int_pending = 0, irq_vector = 8'h00.
REQ-036 Reset mid-service discards all in_service state.
REQ-037 Reset deassertion is used synchronously; the first edge detection occurs no earlier than SYNC_STAGES+1 cycles after release.

Verification (NUM_IRQ = 8, SYNC_STAGES = 2)
REQ-038 Edge on pin 3, mask = 8'hFF, irq_en = 1 -> irq_status = 8'h08 at edge +3, int_pending = 1 at edge +4; int_ack -> irq_vector = 8'h06, in_service = 8'h08, irq_status = 8'h00.
REQ-039 Fixed-mode nesting: in_service = 8'h08, edges on pins 5 then 1 -> only pin 1 wins, vector 8'h02, in_service = 8'h0A; eoi -> 8'h08; second eoi -> 8'h00, then pin 5 wins, vector 8'h0A.
REQ-040 rr mode: pins 0, 2 and 6 pending, rr_ptr = 0 -> successive ack/eoi pairs yield vectors 8'h00, 8'h04, 8'h0C; a re-pended pin 0 then wins with rr_ptr = 7.
REQ-041 Level channel 4 held high across ack -> pending re-sets the next cycle; edge channel with a new edge on the ack cycle -> pending stays 1.
REQ-042 clear_all during service with 3 channels pending -> irq_status = 0, in_service = 0, int_pending = 0 next cycle; int_ack in the same cycle is ignored.
REQ-043 arst pulse while int_pending = 1 and irq_vector = 8'h0E -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Prioritising interrupt controller for the microcode sequencer. Raw pins are
//   synchronised, turned into per-channel set requests (rising edge or level
//   high), collected in a pending register and arbitrated either by fixed
//   priority with nesting (lowest index wins) or round-robin without nesting.
//
// Ports
//   clk           single clock, rising edge
//   arst          asynchronous active-low reset
//   irq_pins      raw asynchronous request pins
//   irq_edge_sel  per channel: 1 = rising-edge, 0 = level-high
//   irq_mask      per channel arbitration enable (pending is set regardless)
//   irq_en        global interrupt enable
//   rr_mode       0 = fixed priority with nesting, 1 = round-robin
//   int_ack       one-cycle acknowledge, honoured only while int_pending = 1
//   eoi           one-cycle end-of-interrupt
//   clear_all     one-cycle clear of pending, in-service, rr pointer, request
//   int_pending   registered interrupt request to the sequencer
//   irq_vector    {zero-extension, winning channel, 1'b0}, held between acks
//   irq_status    pending register
//   in_service    in-service register
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] irq_pins,
  input  logic [NUM_IRQ-1:0] irq_edge_sel,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_en,
  input  logic               rr_mode,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               clear_all,
  output logic               int_pending,
  output logic [7:0]         irq_vector,
  output logic [NUM_IRQ-1:0] irq_status,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam int                 IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [NUM_IRQ-1:0] ONE   = NUM_IRQ'(1);

  logic [NUM_IRQ-1:0] sync_p0 [SYNC_STAGES];
  logic [NUM_IRQ-1:0] hist_p1;
  logic [NUM_IRQ-1:0] req_p2;
  logic [NUM_IRQ-1:0] sync_last;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] lowbit;
  logic [NUM_IRQ-1:0] below;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] ack_bit;
  logic [NUM_IRQ-1:0] eoi_bit;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   rr_next;
  logic               any_elig;
  logic               ack_fire;

  // First set bit of vec, searching upward from start with wrap-around.
  function automatic logic [IDX_W-1:0] first_from(input logic [NUM_IRQ-1:0] vec,
                                                   input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] k;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      k = IDX_W'((int'(start) + i) % NUM_IRQ);
      if (!found && vec[k]) begin
        r     = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    sync_last = sync_p0[SYNC_STAGES-1];
    rise      = sync_last & ~hist_p1;
    set_vec   = (irq_edge_sel & rise) | (~irq_edge_sel & sync_last);
    // lowbit isolates the lowest in-service bit; below is every index under it,
    // which wraps to all ones when nothing is in service.
    lowbit    = in_service & (~in_service + ONE);
    below     = lowbit - ONE;
    if (rr_mode) elig = (in_service == '0) ? (irq_status & irq_mask) : '0;
    else         elig = irq_status & irq_mask & below;
    any_elig  = |elig;
    winner    = first_from(elig, rr_mode ? rr_ptr : '0);
    rr_next   = IDX_W'((int'(winner) + 1) % NUM_IRQ);
    // int_pending lags the pending state by a cycle, so also require a live
    // winner before honouring an acknowledge.
    ack_fire  = int_ack & int_pending & any_elig;
    ack_bit   = ack_fire ? (ONE << winner) : '0;
    // In round-robin mode at most one bit is in service, so the lowest set
    // bit is that bit.
    eoi_bit   = eoi ? lowbit : '0;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
      hist_p1     <= '0;
      req_p2      <= '0;
      irq_status  <= '0;
      in_service  <= '0;
      rr_ptr      <= '0;
      int_pending <= 1'b0;
      irq_vector  <= 8'h00;
    end else begin
      // Stage p0: pin synchroniser chain
      sync_p0[0] <= irq_pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
      // Stage p1: edge history behind the last synchroniser flop
      hist_p1 <= sync_last;
      if (clear_all) begin
        req_p2      <= '0;
        irq_status  <= '0;
        in_service  <= '0;
        rr_ptr      <= '0;
        int_pending <= 1'b0;
      end else begin
        // Stage p2: registered set request per channel
        req_p2      <= set_vec;
        // Pending / in-service update; a same-cycle set beats the ack clear
        irq_status  <= (irq_status & ~ack_bit) | req_p2;
        in_service  <= (in_service & ~eoi_bit) | ack_bit;
        int_pending <= irq_en & any_elig;
        if (ack_fire) begin
          irq_vector <= 8'({winner, 1'b0});
          if (rr_mode) rr_ptr <= rr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         arst;
  logic [N-1:0] irq_pins;
  logic [N-1:0] irq_edge_sel;
  logic [N-1:0] irq_mask;
  logic         irq_en;
  logic         rr_mode;
  logic         int_ack;
  logic         eoi;
  logic         clear_all;
  logic         int_pending;
  logic [7:0]   irq_vector;
  logic [N-1:0] irq_status;
  logic [N-1:0] in_service;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [N-1:0] m_pend, m_isv;
  logic [7:0]   m_vec;
  logic         m_intp;
  int           m_rr;
  logic [N-1:0] ph [S+3];   // ph[j] = pins sampled j edges ago (0 = this edge)
  logic [N-1:0] prev_es;
  logic         prev_clr;

  irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .arst(arst), .irq_pins(irq_pins), .irq_edge_sel(irq_edge_sel),
    .irq_mask(irq_mask), .irq_en(irq_en), .rr_mode(rr_mode), .int_ack(int_ack),
    .eoi(eoi), .clear_all(clear_all), .int_pending(int_pending),
    .irq_vector(irq_vector), .irq_status(irq_status), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_isv = '0; m_vec = '0; m_intp = 1'b0; m_rr = 0;
    for (int j = 0; j < S + 3; j++) ph[j] = '0;
    prev_es = '0; prev_clr = 1'b0;
  endtask

  // One rising edge of the reference: rules applied to pre-edge state.
  task automatic model_edge();
    int lo, win;
    logic any, fire;
    logic [N-1:0] el, setv, ackb, eoib;
    lo = N;
    for (int i = N - 1; i >= 0; i--) if (m_isv[i]) lo = i;
    for (int i = 0; i < N; i++)
      el[i] = m_pend[i] && irq_mask[i] && (rr_mode ? (m_isv == 0) : (i < lo));
    any = (el != 0);
    win = 0;
    if (rr_mode) begin
      for (int k = N - 1; k >= 0; k--) if (el[(m_rr + k) % N]) win = (m_rr + k) % N;
    end else begin
      for (int i = N - 1; i >= 0; i--) if (el[i]) win = i;
    end
    fire = int_ack && m_intp && any;
    for (int j = S + 2; j > 0; j--) ph[j] = ph[j-1];
    ph[0] = irq_pins;
    // A pin change sampled S+1 edges ago reaches pending on this edge.
    for (int i = 0; i < N; i++)
      setv[i] = !prev_clr && (prev_es[i] ? (ph[S+1][i] && !ph[S+2][i]) : ph[S+1][i]);
    ackb = fire ? (8'h01 << win) : 8'h00;
    eoib = (eoi && lo < N) ? (8'h01 << lo) : 8'h00;
    if (clear_all) begin
      m_pend = '0; m_isv = '0; m_rr = 0; m_intp = 1'b0;
    end else begin
      m_pend = (m_pend & ~ackb) | setv;
      m_isv  = (m_isv & ~eoib) | ackb;
      m_intp = irq_en && any;
      if (fire) begin
        m_vec = 8'(win * 2);
        if (rr_mode) m_rr = (win + 1) % N;
      end
    end
    prev_es  = irq_edge_sel;
    prev_clr = clear_all;
  endtask

  task automatic compare_model();
    check("m_status", irq_status, m_pend);
    check("m_insvc", in_service, m_isv);
    check("m_intp", int_pending, m_intp);
    check("m_vector", irq_vector, m_vec);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!arst) model_reset(); else model_edge();
      #1;
      compare_model();
    end
  endtask

  task automatic pulse(input logic [N-1:0] p);
    irq_pins = irq_pins | p;
    tick(1);
    irq_pins = irq_pins & ~p;
  endtask

  task automatic do_ack();
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; tick(1); eoi = 1'b0;
  endtask

  task automatic do_clear();
    clear_all = 1'b1; tick(1); clear_all = 1'b0;
  endtask

  initial begin
    arst = 1'b0; irq_pins = '0; irq_edge_sel = 8'hFF; irq_mask = 8'hFF;
    irq_en = 1'b1; rr_mode = 1'b0; int_ack = 1'b0; eoi = 1'b0; clear_all = 1'b0;
    model_reset();
    #3;
    check("rst_intp", int_pending, 0);
    check("rst_vector", irq_vector, 0);
    check("rst_status", irq_status, 0);
    check("rst_insvc", in_service, 0);
    tick(2);
    arst = 1'b1;
    tick(2);

    // Single edge on pin 3: latency and acknowledge
    irq_pins = 8'h08; tick(1);
    irq_pins = 8'h00; tick(2);
    check("lat_status_e2", irq_status, 8'h00);
    tick(1);
    check("lat_status_e3", irq_status, 8'h08);
    check("lat_intp_e3", int_pending, 0);
    tick(1);
    check("lat_intp_e4", int_pending, 1);
    do_ack();
    check("ack3_vector", irq_vector, 8'h06);
    check("ack3_insvc", in_service, 8'h08);
    check("ack3_status", irq_status, 8'h00);

    // Fixed-mode nesting under channel 3
    pulse(8'h20); tick(4);
    check("nest_p5_status", irq_status, 8'h20);
    check("nest_p5_intp", int_pending, 0);
    pulse(8'h02); tick(4);
    check("nest_status", irq_status, 8'h22);
    check("nest_intp", int_pending, 1);
    do_ack();
    check("nest_vector", irq_vector, 8'h02);
    check("nest_insvc", in_service, 8'h0A);
    do_eoi();
    check("nest_eoi1", in_service, 8'h08);
    tick(1);
    do_eoi();
    check("nest_eoi2", in_service, 8'h00);
    tick(2);
    check("nest_intp_p5", int_pending, 1);
    do_ack();
    check("nest_vector_p5", irq_vector, 8'h0A);
    check("nest_insvc_p5", in_service, 8'h20);
    do_eoi();
    tick(1);

    // Round-robin
    rr_mode = 1'b1;
    do_clear();
    pulse(8'h45); tick(4);
    check("rr_status", irq_status, 8'h45);
    do_ack();
    check("rr_vec0", irq_vector, 8'h00);
    do_eoi(); tick(1);
    do_ack();
    check("rr_vec2", irq_vector, 8'h04);
    do_eoi(); tick(1);
    do_ack();
    check("rr_vec6", irq_vector, 8'h0C);
    check("rr_insvc6", in_service, 8'h40);
    do_eoi();
    pulse(8'h09); tick(4);
    do_ack();
    check("rr_wrap_vec0", irq_vector, 8'h00);
    do_eoi(); tick(1);
    do_ack();
    check("rr_next_vec3", irq_vector, 8'h06);
    do_eoi();
    rr_mode = 1'b0;
    tick(1);

    // Level channel 4 held high across its acknowledge
    do_clear();
    irq_edge_sel = 8'hEF;
    irq_pins = 8'h10; tick(5);
    check("lvl_intp", int_pending, 1);
    do_ack();
    check("lvl_vector", irq_vector, 8'h08);
    check("lvl_insvc", in_service, 8'h10);
    tick(1);
    check("lvl_repend", irq_status, 8'h10);
    irq_pins = 8'h00; tick(4);
    do_clear();
    irq_edge_sel = 8'hFF;

    // Edge channel 2 with a fresh edge landing on the ack cycle
    irq_pins = 8'h04; tick(1);
    irq_pins = 8'h00; tick(1);
    irq_pins = 8'h04; tick(1);
    irq_pins = 8'h00; tick(2);
    check("edge_pre_status", irq_status, 8'h04);
    check("edge_pre_intp", int_pending, 1);
    do_ack();
    check("edge_ack_vector", irq_vector, 8'h04);
    check("edge_setwins", irq_status, 8'h04);
    check("edge_ack_insvc", in_service, 8'h04);
    do_eoi(); tick(2);
    do_ack(); do_eoi(); tick(1);

    // clear_all during service, colliding with an ack
    pulse(8'h0E); tick(4);
    do_ack();
    check("clr_vec", irq_vector, 8'h02);
    check("clr_status_a", irq_status, 8'h0C);
    pulse(8'h01); tick(4);
    check("clr_status_b", irq_status, 8'h0D);
    check("clr_intp_b", int_pending, 1);
    clear_all = 1'b1; int_ack = 1'b1; tick(1);
    clear_all = 1'b0; int_ack = 1'b0;
    check("clr_status", irq_status, 8'h00);
    check("clr_insvc", in_service, 8'h00);
    check("clr_intp", int_pending, 0);
    check("clr_vec_kept", irq_vector, 8'h02);
    tick(3);
    check("clr_no_spurious", irq_status, 8'h00);

    // Asynchronous reset while a request is outstanding
    pulse(8'h80); tick(4);
    do_ack();
    pulse(8'h04); tick(4);
    check("arst_pre_intp", int_pending, 1);
    check("arst_pre_vec", irq_vector, 8'h0E);
    arst = 1'b0;
    #2;
    check("arst_intp", int_pending, 0);
    check("arst_vec", irq_vector, 8'h00);
    check("arst_status", irq_status, 8'h00);
    check("arst_insvc", in_service, 8'h00);
    tick(3);
    arst = 1'b1;
    tick(2);

    // Randomised traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) begin
        irq_edge_sel = N'($urandom);
        irq_mask     = N'($urandom) | N'($urandom);
        rr_mode      = 1'($urandom_range(0, 1));
        irq_en       = ($urandom_range(0, 7) != 0);
      end
      irq_pins  = irq_pins ^ (N'($urandom) & N'($urandom) & N'($urandom));
      int_ack   = ($urandom_range(0, 2) == 0);
      eoi       = ($urandom_range(0, 3) == 0);
      clear_all = ($urandom_range(0, 49) == 0);
      if (c == 700) arst = 1'b0;
      if (c == 703) arst = 1'b1;
      tick(1);
    end
    int_ack = 1'b0; eoi = 1'b0; clear_all = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
